// File: rtl/subservient_sram_bridge_if.sv
// rtl/subservient_sram_bridge_if.sv - subservient byte-wide SRAM port bundle
interface subservient_sram_bridge_if #(
    parameter int AW = 10
);
    logic [AW-1:0] i_sram_waddr;
    logic [7:0]    i_sram_wdata;
    logic          i_sram_wen;
    logic [AW-1:0] i_sram_raddr;
    logic          i_sram_ren;
    logic [7:0]    o_sram_rdata;
    logic          i_flush;
    logic          o_pending;

    modport master (
        output i_sram_waddr, i_sram_wdata, i_sram_wen,
        output i_sram_raddr, i_sram_ren, i_flush,
        input  o_sram_rdata, o_pending
    );

    modport slave (
        input  i_sram_waddr, i_sram_wdata, i_sram_wen,
        input  i_sram_raddr, i_sram_ren, i_flush,
        output o_sram_rdata, o_pending
    );
endinterface

// File: rtl/subservient_sram_bridge.sv
// rtl/subservient_sram_bridge.sv - byte SRAM port to NB banks of 1rw1r 32-bit macros; SRAM_BRIDGE_COALESCE_EN enables write coalescing
module subservient_sram_bridge #(
    parameter int NB            = 1,
    parameter int DEPTH         = 256,
    parameter int FLUSH_TIMEOUT = 8,
    localparam int AW           = $clog2(NB * DEPTH * 4),
    localparam int WAW          = $clog2(DEPTH)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    subservient_sram_bridge_if.slave sram,
    output logic [NB-1:0]       o_csb0,
    output logic [NB*4-1:0]     o_wmask0,
    output logic [NB*WAW-1:0]   o_addr0,
    output logic [NB*32-1:0]    o_din0,
    output logic [NB-1:0]       o_csb1,
    output logic [NB*WAW-1:0]   o_addr1,
    input  logic [NB*32-1:0]    i_dout1
);
    // Bank index is kept at least one bit wide so NB=1 needs no special-case types
    localparam int BWI = (NB > 1) ? $clog2(NB) : 1;

    logic [BWI-1:0] w_bank, r_bank;
    logic [WAW-1:0] w_word, r_word;
    logic [1:0]     w_lane, r_lane;
    logic [3:0]     w_onehot;

    assign w_word   = sram.i_sram_waddr[WAW+1:2];
    assign r_word   = sram.i_sram_raddr[WAW+1:2];
    assign w_lane   = sram.i_sram_waddr[1:0];
    assign r_lane   = sram.i_sram_raddr[1:0];
    assign w_onehot = 4'd1 << w_lane;

    generate
        if (NB > 1) begin : g_multi_bank
            assign w_bank = sram.i_sram_waddr[AW-1:WAW+2];
            assign r_bank = sram.i_sram_raddr[AW-1:WAW+2];
        end else begin : g_single_bank
            assign w_bank = '0;
            assign r_bank = '0;
        end
    endgenerate

    // Read select registers: which bank/lane the macro data comes from next cycle
    logic [BWI-1:0] rsel_bank;
    logic [1:0]     rsel_lane;
    logic           rd_vld;
    logic [7:0]     macro_byte;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsel_bank <= '0;
            rsel_lane <= '0;
            rd_vld    <= 1'b0;
        end else begin
            rd_vld <= sram.i_sram_ren;
            if (sram.i_sram_ren) begin
                rsel_bank <= r_bank;
                rsel_lane <= r_lane;
            end
        end
    end

    assign macro_byte = i_dout1[{rsel_bank, rsel_lane, 3'b000} +: 8];

    // Port1 strobes only the addressed bank; the word address is broadcast
    always_comb begin
        o_csb1  = '1;
        o_addr1 = '0;
        for (int b = 0; b < NB; b++) begin
            o_csb1[b]            = !(sram.i_sram_ren && (r_bank == BWI'(b)));
            o_addr1[b*WAW +: WAW] = r_word;
        end
    end

`ifdef SRAM_BRIDGE_COALESCE_EN
    localparam int IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    logic           pend_valid;
    logic [BWI-1:0] pend_bank;
    logic [WAW-1:0] pend_waddr;
    logic [31:0]    pend_data;
    logic [3:0]     pend_mask;
    logic [IW-1:0]  idle;
    logic           hit, timeout, flush;
    logic [31:0]    mdata;
    logic [3:0]     mmask;
    logic           fwd;
    logic [7:0]     fwd_byte;

    // Flush decision and the pending word merged with a same-word incoming byte
    always_comb begin
        hit     = sram.i_sram_wen && pend_valid &&
                  (w_bank == pend_bank) && (w_word == pend_waddr);
        timeout = (FLUSH_TIMEOUT != 0) && (idle == IW'(FLUSH_TIMEOUT));
        flush   = pend_valid && (sram.i_flush || (pend_mask == 4'hF) || timeout ||
                                 (sram.i_sram_wen && !hit));
        mdata   = pend_data;
        mmask   = pend_mask;
        if (hit) begin
            mdata[{w_lane, 3'b000} +: 8] = sram.i_sram_wdata;
            mmask                        = pend_mask | w_onehot;
        end
    end

    // Port0 writes the merged word to the pending bank only on a flush
    always_comb begin
        o_csb0   = '1;
        o_wmask0 = '0;
        o_addr0  = '0;
        o_din0   = '0;
        for (int b = 0; b < NB; b++) begin
            o_csb0[b]             = !(flush && (pend_bank == BWI'(b)));
            o_wmask0[b*4 +: 4]    = (flush && (pend_bank == BWI'(b))) ? mmask : 4'h0;
            o_addr0[b*WAW +: WAW] = pend_waddr;
            o_din0[b*32 +: 32]    = mdata;
        end
    end

    // Coalescing buffer and idle counter update
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pend_valid <= 1'b0;
            pend_bank  <= '0;
            pend_waddr <= '0;
            pend_data  <= '0;
            pend_mask  <= '0;
            idle       <= '0;
        end else begin
            if (flush) begin
                if (sram.i_sram_wen && !hit) begin
                    pend_valid                       <= 1'b1;
                    pend_bank                        <= w_bank;
                    pend_waddr                       <= w_word;
                    pend_data[{w_lane, 3'b000} +: 8] <= sram.i_sram_wdata;
                    pend_mask                        <= w_onehot;
                end else begin
                    pend_valid <= 1'b0;
                    pend_mask  <= 4'h0;
                end
            end else if (sram.i_sram_wen) begin
                pend_valid                       <= 1'b1;
                pend_bank                        <= w_bank;
                pend_waddr                       <= w_word;
                pend_data[{w_lane, 3'b000} +: 8] <= sram.i_sram_wdata;
                pend_mask                        <= pend_mask | w_onehot;
            end
            if (sram.i_sram_wen || flush)
                idle <= '0;
            else if (pend_valid && (idle != IW'(FLUSH_TIMEOUT)))
                idle <= idle + 1'b1;
        end
    end

    // Forwarding capture uses the buffer as it was before this edge's update
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fwd      <= 1'b0;
            fwd_byte <= '0;
        end else if (sram.i_sram_ren) begin
            fwd      <= pend_valid && (pend_bank == r_bank) &&
                        (pend_waddr == r_word) && pend_mask[r_lane];
            fwd_byte <= pend_data[{r_lane, 3'b000} +: 8];
        end
    end

    assign sram.o_sram_rdata = rd_vld ? (fwd ? fwd_byte : macro_byte) : 8'h00;
    assign sram.o_pending    = pend_valid;
`else
    wire unused_flush = sram.i_flush;

    // Every byte write goes straight to port0 of the addressed bank
    always_comb begin
        o_csb0   = '1;
        o_wmask0 = '0;
        o_addr0  = '0;
        o_din0   = '0;
        for (int b = 0; b < NB; b++) begin
            o_csb0[b]             = !(sram.i_sram_wen && (w_bank == BWI'(b)));
            o_wmask0[b*4 +: 4]    = (sram.i_sram_wen && (w_bank == BWI'(b))) ? w_onehot : 4'h0;
            o_addr0[b*WAW +: WAW] = w_word;
            o_din0[b*32 +: 32]    = {4{sram.i_sram_wdata}};
        end
    end

    assign sram.o_sram_rdata = rd_vld ? macro_byte : 8'h00;
    assign sram.o_pending    = 1'b0;
`endif
endmodule

// File: tb/tb_subservient_sram_bridge.sv
// tb/tb_subservient_sram_bridge.sv - directed bench for subservient_sram_bridge with NB=4, DEPTH=256
module tb_subservient_sram_bridge;
    localparam int NB  = 4;
    localparam int AW  = 12;
    localparam int WAW = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NB-1:0]       csb0, csb1;
    logic [NB*4-1:0]     wmask0;
    logic [NB*WAW-1:0]   addr0, addr1;
    logic [NB*32-1:0]    din0;
    logic [NB*32-1:0]    dout1 = '0;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int saved;

    logic [31:0] mem [NB][256];

    subservient_sram_bridge_if #(.AW(AW)) sif ();

    subservient_sram_bridge #(.NB(NB), .DEPTH(256), .FLUSH_TIMEOUT(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .sram     (sif),
        .o_csb0   (csb0),
        .o_wmask0 (wmask0),
        .o_addr0  (addr0),
        .o_din0   (din0),
        .o_csb1   (csb1),
        .o_addr1  (addr1),
        .i_dout1  (dout1)
    );

    always #5 clk = ~clk;

    // Macro model: read-before-write, registered port1 data
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!csb1[b]) dout1[b*32 +: 32] <= mem[b][addr1[b*WAW +: WAW]];
            if (!csb0[b]) begin
                for (int k = 0; k < 4; k++)
                    if (wmask0[b*4 + k])
                        mem[b][addr0[b*WAW +: WAW]][k*8 +: 8] <= din0[b*32 + k*8 +: 8];
            end
        end
        if (csb0 != '1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [AW-1:0] wa, input logic [7:0] wd,
                         input logic ren, input logic [AW-1:0] ra, input logic fl);
        @(negedge clk);
        sif.i_sram_wen   = wen;
        sif.i_sram_waddr = wa;
        sif.i_sram_wdata = wd;
        sif.i_sram_ren   = ren;
        sif.i_sram_raddr = ra;
        sif.i_flush      = fl;
        #2;
    endtask

    task automatic idle_cyc();
        drive(1'b0, '0, 8'h00, 1'b0, '0, 1'b0);
    endtask

    initial begin
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 256; w++)
                mem[b][w] = 32'h0;
        sif.i_sram_wen = 1'b0; sif.i_sram_waddr = '0; sif.i_sram_wdata = '0;
        sif.i_sram_ren = 1'b0; sif.i_sram_raddr = '0; sif.i_flush = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_pending", sif.o_pending, 1'b0);
        chk("reset_rdata", sif.o_sram_rdata, 8'h00);
        chk("reset_csb0", csb0, 4'hF);
        chk("reset_csb1", csb1, 4'hF);
        @(negedge clk);
        rst = 1'b0;

`ifdef SRAM_BRIDGE_COALESCE_EN
        // reset mid-merge discards the two pending bytes
        drive(1'b1, 12'h100, 8'h11, 1'b0, '0, 1'b0);
        drive(1'b1, 12'h101, 8'h22, 1'b0, '0, 1'b0);
        idle_cyc();
        chk("merge_pending", sif.o_pending, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_pending", sif.o_pending, 1'b0);
        chk("midrst_csb0", csb0, 4'hF);
        chk("midrst_csb1", csb1, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        saved = wr_cnt;
        repeat (12) idle_cyc();
        chk("midrst_no_write", wr_cnt, saved);

        // four bytes coalesce into a single full-mask write
        saved = wr_cnt;
        drive(1'b1, 12'h100, 8'h11, 1'b0, '0, 1'b0);
        chk("w4_b0_csb0", csb0, 4'hF);
        drive(1'b1, 12'h101, 8'h22, 1'b0, '0, 1'b0);
        drive(1'b1, 12'h102, 8'h33, 1'b0, '0, 1'b0);
        drive(1'b1, 12'h103, 8'h44, 1'b0, '0, 1'b0);
        chk("w4_b3_csb0", csb0, 4'hF);
        idle_cyc();
        chk("w4_csb0", csb0, 4'hE);
        chk("w4_wmask", wmask0, 16'h000F);
        chk("w4_addr0", addr0[7:0], 8'h40);
        chk("w4_din0", din0[31:0], 32'h44332211);
        idle_cyc();
        chk("w4_after_csb0", csb0, 4'hF);
        chk("w4_after_pending", sif.o_pending, 1'b0);
        chk("w4_write_count", wr_cnt - saved, 1);

        // write to a different word evicts the pending one
        drive(1'b1, 12'h104, 8'hAA, 1'b0, '0, 1'b0);
        chk("evict_first_csb0", csb0, 4'hF);
        drive(1'b1, 12'h208, 8'hBB, 1'b0, '0, 1'b0);
        chk("evict_csb0", csb0, 4'hE);
        chk("evict_wmask", wmask0, 16'h0001);
        chk("evict_addr0", addr0[7:0], 8'h41);
        chk("evict_din0", din0[7:0], 8'hAA);
        idle_cyc();
        chk("evict_pending", sif.o_pending, 1'b1);
        chk("evict_idle_csb0", csb0, 4'hF);
        drive(1'b0, '0, 8'h00, 1'b0, '0, 1'b1);
        chk("force_csb0", csb0, 4'hE);
        chk("force_wmask", wmask0, 16'h0001);
        chk("force_addr0", addr0[7:0], 8'h82);
        chk("force_din0", din0[7:0], 8'hBB);
        idle_cyc();

        // forwarded read, then timeout flush after 8 idle cycles
        drive(1'b1, 12'h010, 8'h5A, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 8'h00, 1'b1, 12'h010, 1'b0);
        chk("fwd_csb1", csb1, 4'hE);
        chk("fwd_addr1", addr1[7:0], 8'h04);
        chk("fwd_csb0", csb0, 4'hF);
        idle_cyc();
        chk("fwd_rdata", sif.o_sram_rdata, 8'h5A);
        chk("fwd_nowrite_csb0", csb0, 4'hF);
        for (int i = 3; i <= 8; i++) begin
            idle_cyc();
            chk($sformatf("to_wait_%0d", i), csb0, 4'hF);
        end
        idle_cyc();
        chk("to_csb0", csb0, 4'hE);
        chk("to_addr0", addr0[7:0], 8'h04);
        chk("to_wmask", wmask0, 16'h0001);
        chk("to_din0", din0[7:0], 8'h5A);
        idle_cyc();
        chk("to_pending", sif.o_pending, 1'b0);

        // same-cycle read and write of one byte returns the older value
        drive(1'b1, 12'h010, 8'h66, 1'b1, 12'h010, 1'b0);
        drive(1'b0, '0, 8'h00, 1'b1, 12'h010, 1'b0);
        chk("rw_old_rdata", sif.o_sram_rdata, 8'h5A);
        idle_cyc();
        chk("rw_new_rdata", sif.o_sram_rdata, 8'h66);
        drive(1'b0, '0, 8'h00, 1'b0, '0, 1'b1);
        chk("rw_flush_csb0", csb0, 4'hE);
        chk("rw_flush_din0", din0[7:0], 8'h66);
        idle_cyc();

        // bank 3 write and read through the macro
        drive(1'b1, 12'hC05, 8'h9C, 1'b0, '0, 1'b0);
        chk("b3_wr_csb0", csb0, 4'hF);
        drive(1'b0, '0, 8'h00, 1'b0, '0, 1'b1);
        chk("b3_flush_csb0", csb0, 4'h7);
        chk("b3_flush_wmask", wmask0, 16'h2000);
        chk("b3_flush_addr0", addr0[31:24], 8'h01);
        chk("b3_flush_din0", din0[111:104], 8'h9C);
        drive(1'b0, '0, 8'h00, 1'b1, 12'hC05, 1'b0);
        chk("b3_rd_csb1", csb1, 4'h7);
        chk("b3_rd_addr1", addr1[31:24], 8'h01);
        idle_cyc();
        chk("b3_rdata", sif.o_sram_rdata, 8'h9C);
`else
        // immediate writes without coalescing
        drive(1'b1, 12'h003, 8'h77, 1'b0, '0, 1'b0);
        chk("imm_csb0", csb0, 4'hE);
        chk("imm_wmask", wmask0, 16'h0008);
        chk("imm_din0", din0[31:0], 32'h77777777);
        chk("imm_addr0", addr0[7:0], 8'h00);
        chk("imm_pending", sif.o_pending, 1'b0);
        drive(1'b1, 12'hC05, 8'h9C, 1'b0, '0, 1'b0);
        chk("imm_b3_csb0", csb0, 4'h7);
        chk("imm_b3_wmask", wmask0, 16'h2000);
        chk("imm_b3_addr0", addr0[31:24], 8'h01);
        chk("imm_b3_din0", din0[111:104], 8'h9C);
        drive(1'b0, '0, 8'h00, 1'b1, 12'hC05, 1'b0);
        chk("imm_b3_csb1", csb1, 4'h7);
        chk("imm_b3_addr1", addr1[31:24], 8'h01);
        drive(1'b0, '0, 8'h00, 1'b1, 12'h003, 1'b0);
        chk("imm_b3_rdata", sif.o_sram_rdata, 8'h9C);
        chk("imm_b0_csb1", csb1, 4'hE);
        idle_cyc();
        chk("imm_b0_rdata", sif.o_sram_rdata, 8'h77);
        chk("imm_idle_rdata_csb1", csb1, 4'hF);
        drive(1'b0, '0, 8'h00, 1'b0, '0, 1'b1);
        chk("imm_flush_ignored", csb0, 4'hF);
        chk("imm_flush_pending", sif.o_pending, 1'b0);
        idle_cyc();
        chk("imm_idle_rdata", sif.o_sram_rdata, 8'h00);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
